// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register. It captures the operands, register indices, the extended immediate and the control word.
// It supports stall (hold), flush (bubble) and sign/zero immediate extension.
// Define IDEX_STATS_EN to add saturating stall/flush event counters.
module id_ex_pipe_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 12
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_i,
  input  logic [DW-1:0] rd1_i,
  input  logic [DW-1:0] rd2_i,
  input  logic [RW-1:0] rs_i,
  input  logic [RW-1:0] rt_i,
  input  logic [RW-1:0] rd_i,
  input  logic [15:0]   imm_i,
  input  logic          zext_i,
  input  logic [CW-1:0] ctrl_i,
  output logic          valid_o,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o,
  output logic [RW-1:0] rs_o,
  output logic [RW-1:0] rt_o,
  output logic [RW-1:0] rd_o,
  output logic [DW-1:0] imm_o,
`ifdef IDEX_STATS_EN
  output logic [CW-1:0] ctrl_o,
  output logic [15:0]   stall_cnt_o,
  output logic [15:0]   flush_cnt_o
`else
  output logic [CW-1:0] ctrl_o
`endif
);

  localparam int unsigned IMMW = 16;

  logic [DW-1:0] imm_ext_c;

  // Immediate extension; a 16-bit datapath passes the field through unchanged
  generate
    if (DW > IMMW) begin : g_ext
      always_comb imm_ext_c = {{(DW-IMMW){imm_i[15] & ~zext_i}}, imm_i};
    end else begin : g_noext
      always_comb imm_ext_c = imm_i;
    end
  endgenerate

  // Priority on each edge: clr, flush, stall, load
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      valid_o <= 1'b0;
      rd1_o   <= '0;
      rd2_o   <= '0;
      rs_o    <= '0;
      rt_o    <= '0;
      rd_o    <= '0;
      imm_o   <= '0;
      ctrl_o  <= '0;
    end else if (!stall) begin
      valid_o <= valid_i;
      rd1_o   <= rd1_i;
      rd2_o   <= rd2_i;
      rs_o    <= rs_i;
      rt_o    <= rt_i;
      rd_o    <= rd_i;
      imm_o   <= imm_ext_c;
      // An invalid slot carries a zero (no-op) control word
      ctrl_o  <= valid_i ? ctrl_i : '0;
    end
  end

`ifdef IDEX_STATS_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall && !flush && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
      if (flush && (flush_cnt_o != 16'hFFFF))
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed steps plus a random phase.
// All expectations come from a register-state model built from the priority rules.
module tb_id_ex_pipe_reg;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          clr, stall, flush, valid_i, zext_i;
  logic [DW-1:0] rd1_i, rd2_i;
  logic [RW-1:0] rs_i, rt_i, rd_i;
  logic [15:0]   imm_i;
  logic [CW-1:0] ctrl_i;
  logic          valid_o;
  logic [DW-1:0] rd1_o, rd2_o, imm_o;
  logic [RW-1:0] rs_o, rt_o, rd_o;
  logic [CW-1:0] ctrl_o;
`ifdef IDEX_STATS_EN
  logic [15:0]   stall_cnt_o, flush_cnt_o;
  int            m_sc, m_fc;
`endif

  int tests = 0;
  int fails = 0;

  // Model of the execute-side state
  logic          m_valid;
  logic [DW-1:0] m_rd1, m_rd2, m_imm;
  logic [RW-1:0] m_rs, m_rt, m_rd;
  logic [CW-1:0] m_ctrl;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush), .valid_i(valid_i),
    .rd1_i(rd1_i), .rd2_i(rd2_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .imm_i(imm_i), .zext_i(zext_i), .ctrl_i(ctrl_i),
    .valid_o(valid_o), .rd1_o(rd1_o), .rd2_o(rd2_o), .rs_o(rs_o), .rt_o(rt_o),
    .rd_o(rd_o), .imm_o(imm_o),
`ifdef IDEX_STATS_EN
    .ctrl_o(ctrl_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`else
    .ctrl_o(ctrl_o)
`endif
  );

  // Extended immediate as a numeric value: negative 16-bit values wrap into DW bits
  function automatic logic [DW-1:0] ext_imm(input logic [15:0] imm, input logic z);
    longint v;
    v = longint'(imm);
    if (!z && v >= 32768) v = v - 65536;
    return DW'(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_inputs();
    valid_i = 1'($urandom);
    rd1_i   = DW'($urandom);
    rd2_i   = DW'($urandom);
    rs_i    = RW'($urandom);
    rt_i    = RW'($urandom);
    rd_i    = RW'($urandom);
    imm_i   = 16'($urandom);
    zext_i  = 1'($urandom);
    ctrl_i  = CW'($urandom);
  endtask

  task automatic check_all();
    chk("valid", 64'(valid_o), 64'(m_valid));
    chk("rd1",   64'(rd1_o),   64'(m_rd1));
    chk("rd2",   64'(rd2_o),   64'(m_rd2));
    chk("rs",    64'(rs_o),    64'(m_rs));
    chk("rt",    64'(rt_o),    64'(m_rt));
    chk("rd",    64'(rd_o),    64'(m_rd));
    chk("imm",   64'(imm_o),   64'(m_imm));
    chk("ctrl",  64'(ctrl_o),  64'(m_ctrl));
`ifdef IDEX_STATS_EN
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_sc));
    chk("flush_cnt", 64'(flush_cnt_o), 64'(m_fc));
`endif
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then check
  task automatic tick();
    @(posedge clk);
`ifdef IDEX_STATS_EN
    if (clr) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (stall && !flush && m_sc < 65535) m_sc++;
      if (flush && m_fc < 65535) m_fc++;
    end
`endif
    if (clr || flush) begin
      m_valid = 0; m_rd1 = '0; m_rd2 = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      m_imm = '0; m_ctrl = '0;
    end else if (!stall) begin
      m_valid = valid_i; m_rd1 = rd1_i; m_rd2 = rd2_i;
      m_rs = rs_i; m_rt = rt_i; m_rd = rd_i;
      m_imm = ext_imm(imm_i, zext_i);
      m_ctrl = valid_i ? ctrl_i : '0;
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset with every input nonzero
    clr = 1; stall = 0; flush = 0;
    valid_i = 1; rd1_i = '1; rd2_i = 32'h5A5A5A5A; rs_i = 5'd3; rt_i = 5'd4; rd_i = 5'd5;
    imm_i = 16'hFFFF; zext_i = 1; ctrl_i = 12'hFFF;
    tick();
    tick();
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_ctrl",  64'(ctrl_o),  64'd0);

    // First load right after release
    clr = 0;
    randomize_inputs();
    valid_i = 1;
    tick();

    // Immediate extension and operand capture
    imm_i = 16'h8001; zext_i = 0; rd1_i = 32'hDEADBEEF;
    tick();
    chk("imm_sext", 64'(imm_o), 64'h0000_0000_FFFF_8001);
    chk("rd1_load", 64'(rd1_o), 64'h0000_0000_DEAD_BEEF);
    zext_i = 1;
    tick();
    chk("imm_zext", 64'(imm_o), 64'h0000_0000_0000_8001);
    imm_i = 16'h7FFF; zext_i = 0;
    tick();
    chk("imm_sext_pos", 64'(imm_o), 64'h0000_0000_0000_7FFF);

    // Stall holds everything
    rs_i = 5'd7;
    tick();
    stall = 1; rs_i = 5'd9;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      rs_i = 5'd9;
      tick();
      chk("stall_rs_hold", 64'(rs_o), 64'd7);
    end
    stall = 0;
    tick();
    chk("stall_release_rs", 64'(rs_o), 64'd9);

    // Flush beats a simultaneous stall
    randomize_inputs();
    stall = 1; flush = 1; valid_i = 1; ctrl_i = 12'hABC;
    tick();
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_ctrl",  64'(ctrl_o),  64'd0);
    chk("flush_rd1",   64'(rd1_o),   64'd0);
    stall = 0; flush = 0;

    // Invalid slot: control zeroed, data still loaded
    randomize_inputs();
    valid_i = 0; ctrl_i = 12'hFFF; rd2_i = 32'h1234;
    tick();
    chk("inv_ctrl",  64'(ctrl_o),  64'd0);
    chk("inv_valid", 64'(valid_o), 64'd0);
    chk("inv_rd2",   64'(rd2_o),   64'h1234);

    // clr wins over a stall
    randomize_inputs(); valid_i = 1;
    tick();
    stall = 1; clr = 1;
    tick();
    chk("clr_in_stall", 64'(valid_o), 64'd0);
    stall = 0; clr = 0;

    // Random phase
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      clr   = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 3) == 0);
      tick();
    end

`ifdef IDEX_STATS_EN
    clr = 1; stall = 0; flush = 0;
    tick();
    clr = 0;
    stall = 1;
    for (int i = 0; i < 5; i++) tick();
    stall = 0; flush = 1;
    for (int i = 0; i < 2; i++) tick();
    stall = 1;
    tick();
    chk("stat_stall5", 64'(stall_cnt_o), 64'd5);
    chk("stat_flush3", 64'(flush_cnt_o), 64'd3);
    stall = 0; flush = 0;
    @(negedge clk);
    force dut.stall_cnt_o = 16'hFFFE;
    @(negedge clk);
    release dut.stall_cnt_o;
    m_sc = 65534;
    stall = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("stat_saturate", 64'(stall_cnt_o), 64'hFFFF);
    stall = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register for the pipelined MIPS core. It sits between the decode stage (register file read, immediate field) and the execute stage.
It captures the operands, register indices, extended immediate and control word, with a valid bit. It supports stall (hold), flush (bubble insertion) and selectable sign/zero extension of the 16-bit immediate.
It generalises the fixed 32-bit ID/EX latch by adding width parameters, a control bus, a valid bit, stall/flush handling and a correctly registered immediate.

Parameters:
DW, 32, operand/immediate output width (>=16)
RW, 5, register index width
CW, 12, decoded control word width

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  reset, synchronous, active-high
stall  in  1  hold all registers (hazard unit)
flush  in  1  insert bubble (branch/hazard unit)
valid_i  in  1  decode stage holds a real instruction
rd1_i  in  DW  register file read port 1
rd2_i  in  DW  register file read port 2
rs_i  in  RW  source index rs
rt_i  in  RW  source index rt
rd_i  in  RW  destination index rd
imm_i  in  16  raw immediate field
zext_i  in  1  1 = zero-extend imm_i, 0 = sign-extend
ctrl_i  in  CW  decoded control word
valid_o  out  1  execute stage holds a real instruction
rd1_o  out  DW  registered rd1
rd2_o  out  DW  registered rd2
rs_o  out  RW  registered rs
rt_o  out  RW  registered rt
rd_o  out  RW  registered rd
imm_o  out  DW  registered extended immediate
ctrl_o  out  CW  registered control word

Behaviour:
- One register stage, latency 1 cycle. All outputs are driven directly from flops.
- Per-edge priority: clr > flush > stall > load.
- clr=1: every output is 0 on the next edge. This includes valid_o and ctrl_o, and any counters under the optional feature. clr asserted mid-stall or mid-flush still clears.
- flush=1 (clr=0): bubble. valid_o=0, ctrl_o=0, and all data/index outputs=0. Flush wins over a simultaneous stall.
- stall=1 (clr=0, flush=0): every output holds its previous value, including valid_o.
- load (all of clr, flush, stall = 0): every output takes its _i value.
  - valid_o=valid_i.
  - When valid_i=0, ctrl_o is forced to 0 and data fields are still loaded. Execute must treat ctrl=0 as a no-op.
- Immediate extension:
  - zext_i=0: imm_o = {(DW-16) copies of imm_i[15], imm_i}.
  - zext_i=1: imm_o = {(DW-16) zeros, imm_i}.
  - DW=16: imm_o = imm_i for either value of zext_i.
- No combinational path from any input to any output.

Optional Feature:
Macro IDEX_STATS_EN.
- Defined: adds outputs stall_cnt_o[15:0] and flush_cnt_o[15:0].
  - stall_cnt_o counts edges where stall=1 and flush=0 and clr=0.
  - flush_cnt_o counts edges where flush=1 and clr=0.
  - Both saturate at 16'hFFFF and do not wrap. Both reset to 0 on clr.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold clr=1 for 2 cycles with all inputs at nonzero values -> every output 0. Release -> the first load appears 1 edge later.
- Load/extend, DW=32: imm_i=16'h8001, zext_i=0 -> imm_o=32'hFFFF8001. Next cycle zext_i=1 -> imm_o=32'h00008001. rd1_i=32'hDEADBEEF -> rd1_o=32'hDEADBEEF after 1 edge.
- Stall: load rs_i=5'd7, then stall=1 for 3 cycles with rs_i=5'd9 -> rs_o stays 7 for those 3 cycles. Drop stall -> rs_o=9 on the next edge.
- Flush with stall: stall=1 and flush=1 on the same edge, valid_i=1, ctrl_i=12'hABC -> valid_o=0, ctrl_o=0, rd1_o=0.
- valid_i=0 load: ctrl_i=12'hFFF, rd2_i=32'h1234 -> ctrl_o=0, valid_o=0, rd2_o=32'h1234.
- IDEX_STATS_EN: 5 stall cycles, then 2 flush cycles, then 1 edge with stall and flush together -> stall_cnt_o=5, flush_cnt_o=3. Force the count to 16'hFFFE, apply 3 more stalls -> stall_cnt_o=16'hFFFF.
